// File: rtl/seq_pkg.sv
// Shared types for the serial pattern generator and the sequence detectors.
// State encoding is 2 bits so detector state types can reuse it.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  localparam int unsigned SEQ_PAT_W = 8;
  localparam int unsigned SEQ_REP_W = 4;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable pattern register with a wrapping bit-index down-counter.
// bit_o is the bit selected by the index that takes effect at the next edge.
module seq_gen_shreg
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       adv_i,
  input  logic [PAT_W-1:0]           pat_i,
  input  logic [$clog2(PAT_W+1)-1:0] len_i,
  output logic                       bit_o,
  output logic                       last_o
);

  localparam int IW = $clog2(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IW-1:0]    top_q, top_d;
  logic [IW-1:0]    idx_q, idx_d;

  assign last_o = (idx_q == '0);

  always_comb begin
    pat_d = pat_q;
    top_d = top_q;
    idx_d = idx_q;
    if (load_i) begin
      pat_d = pat_i;
      top_d = IW'(len_i - 1'b1);
      idx_d = top_d;
    end else if (adv_i) begin
      // Wrap to the top index so repetitions run without a bubble.
      idx_d = last_o ? top_q : idx_q - IW'(1);
    end
  end

  assign bit_o = pat_d[idx_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      top_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      top_q <= top_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: MSB-first, repeated, with done pulse.
// Define SEQ_GEN_GAP_EN to insert GAP_CYC idle cycles between repetitions.
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_W   = SEQ_PAT_W,
  parameter int REP_W   = SEQ_REP_W,
  parameter int GAP_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(PAT_W+1);

  seq_state_e       state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [LW-1:0]    len_sat;
  logic             load, adv, nbit, last;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef SEQ_GEN_GAP_EN
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC+1) : 1;
  logic [GW-1:0] gap_q, gap_d;
`endif

  assign len_sat = (len > LW'(PAT_W)) ? LW'(PAT_W) : len;

  seq_gen_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (load),
    .adv_i  (adv),
    .pat_i  (pattern),
    .len_i  (len_sat),
    .bit_o  (nbit),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    load    = 1'b0;
    adv     = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_d   = gap_q;
`endif
    if (abort) begin
      state_d = IDLE;
      rep_d   = '0;
`ifdef SEQ_GEN_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rep_d = (reps == '0) ? REP_W'(1) : reps;
            if (len_sat == '0) begin
              state_d = FIN;
            end else begin
              state_d = SHIFT;
              load    = 1'b1;
            end
          end
        end
        SHIFT: begin
          adv = 1'b1;
          if (last) begin
            if (rep_q > REP_W'(1)) begin
              rep_d = rep_q - REP_W'(1);
`ifdef SEQ_GEN_GAP_EN
              state_d = GAP;
              gap_d   = GW'(GAP_CYC);
`endif
            end else begin
              state_d = FIN;
              rep_d   = '0;
            end
          end
        end
        GAP: begin
`ifdef SEQ_GEN_GAP_EN
          if (gap_q <= GW'(1)) begin
            state_d = SHIFT;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GW'(1);
          end
`else
          state_d = IDLE;
`endif
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Outputs are registered decodes of the state being entered.
    vld_d  = (state_d == SHIFT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    out_d  = vld_d & nbit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rep_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_GEN_GAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gap_q <= '0;
    else      gap_q <= gap_d;
  end
`endif

  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed testbench for seq_gen; observed vector is {busy,done,out_valid,out}.
// Honours SEQ_GEN_GAP_EN when the design is built with the gap feature.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       out, out_valid, busy, done;
  logic [3:0] obs;

  int n_vec = 0;
  int n_err = 0;

  seq_gen #(
    .PAT_W   (8),
    .REP_W   (4),
    .GAP_CYC (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, out_valid, out};

  // Called at a falling edge; returns at the falling edge of cycle E0.
  task automatic go(input logic [7:0] p, input logic [3:0] l,
                    input logic [3:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async got %b want 0000", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle got %b want 0000", obs);
    end
  endtask

  task automatic test_three_ones;
    int run;
    bit hit;
    logic [3:0] exp;
    run = 0;
    hit = 1'b0;
    go(8'h07, 4'd3, 4'd1);
    for (int i = 0; i < 5; i++) begin
      exp = (i < 3) ? 4'b1011 : (i == 3) ? 4'b1100 : 4'b0000;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL three_ones cyc%0d got %b want %b", i, obs, exp);
      end
      if (out_valid && out) run++;
      else run = 0;
      if (run >= 3) hit = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (hit !== 1'b1) begin
      n_err++;
      $display("FAIL three_ones_detect got %b want 1", hit);
    end
  endtask

  task automatic test_repeat;
    logic [15:0] bits;
    logic [3:0]  exp;
    int total, k;
    bits = 16'hA5A5;
`ifdef SEQ_GEN_GAP_EN
    total = 20;
`else
    total = 18;
`endif
    go(8'hA5, 4'd8, 4'd2);
    for (int i = 0; i < total; i++) begin
      k = i;
`ifdef SEQ_GEN_GAP_EN
      if (i >= 10) k = i - 2;
      if (i == 8 || i == 9) exp = 4'b1000;
      else if (k < 16) exp = {3'b101, bits[15-k]};
`else
      if (k < 16) exp = {3'b101, bits[15-k]};
`endif
      else if (k == 16) exp = 4'b1100;
      else exp = 4'b0000;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL repeat cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    logic [7:0] p;
    logic [3:0] exp;
    p = 8'b1011_0110;
    go(p, 4'd8, 4'd1);
    for (int i = 0; i < 4; i++) begin
      exp = {3'b101, p[7-i]};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL abort_pre cyc%0d got %b want %b", i, obs, exp);
      end
      if (i == 3) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs !== 4'b0000) begin
        n_err++;
        $display("FAIL abort_post cyc%0d got %b want 0000", i, obs);
      end
      if (i == 0) @(negedge clk);
    end
    go(8'h07, 4'd3, 4'd1);
    for (int i = 0; i < 4; i++) begin
      exp = (i < 3) ? 4'b1011 : 4'b1100;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL abort_restart cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_start;
    logic [5:0] b;
    logic [3:0] exp;
    b = 6'b111100;
    go(8'h3C, 4'd6, 4'd1);
    for (int i = 0; i < 8; i++) begin
      exp = (i < 6) ? {3'b101, b[5-i]} : (i == 6) ? 4'b1100 : 4'b0000;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL busy_start cyc%0d got %b want %b", i, obs, exp);
      end
      if (i == 1) begin
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'd2;
        reps    = 4'd3;
      end
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_len0;
    logic [3:0] exp;
    go(8'h55, 4'd0, 4'd2);
    for (int i = 0; i < 2; i++) begin
      exp = (i == 0) ? 4'b1100 : 4'b0000;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL len0 cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reps0;
    logic [3:0] exp;
    go(8'h02, 4'd2, 4'd0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       exp = 4'b1011;
        1:       exp = 4'b1010;
        2:       exp = 4'b1100;
        default: exp = 4'b0000;
      endcase
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reps0 cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_len_sat;
    logic [7:0] p;
    logic [3:0] exp;
    p = 8'h81;
    go(p, 4'd15, 4'd1);
    for (int i = 0; i < 10; i++) begin
      exp = (i < 8) ? {3'b101, p[7-i]} : (i == 8) ? 4'b1100 : 4'b0000;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL len_sat cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_abort;
    pattern = 8'h07;
    len     = 4'd3;
    reps    = 4'd1;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs !== 4'b0000) begin
        n_err++;
        $display("FAIL start_abort cyc%0d got %b want 0000", i, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    go(8'h03, 4'd2, 4'd1);
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2) ? 4'b1011 : 4'b1100;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b_first cyc%0d got %b want %b", i, obs, exp);
      end
      if (i == 2) begin
        pattern = 8'h07;
        len     = 4'd3;
        reps    = 4'd1;
        start   = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL b2b_done_start got %b want 0000", obs);
    end
    go(8'h05, 4'd3, 4'd1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       exp = 4'b1011;
        1:       exp = 4'b1010;
        2:       exp = 4'b1011;
        3:       exp = 4'b1100;
        default: exp = 4'b0000;
      endcase
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b_second cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp;
    go(8'hFF, 4'd8, 4'd1);
    @(negedge clk);
    n_vec++;
    if (obs !== 4'b1011) begin
      n_err++;
      $display("FAIL rst_mid_pre got %b want 1011", obs);
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid_async got %b want 0000", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid_release got %b want 0000", obs);
    end
    go(8'h07, 4'd3, 4'd1);
    for (int i = 0; i < 4; i++) begin
      exp = (i < 3) ? 4'b1011 : 4'b1100;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rst_mid_restart cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_three_ones;
    test_repeat;
    test_abort;
    test_busy_start;
    test_len0;
    test_reps0;
    test_len_sat;
    test_start_abort;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter that produces the bit stream consumed by the team's serial sequence detectors. It loads a parallel pattern, shifts it out MSB-first one bit per clock, optionally repeats it, and flags completion. It sits on the stimulus side of the detector path and drives the detector's `in` pin directly.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `REP_W`, 4: width of the repeat-count input.
- `GAP_CYC`, 2: idle cycles between repetitions; used only with the gap feature compiled in.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low. Low forces reset immediately; release is synchronous to `clk` upstream.
- `start` input 1: request a transmission; sampled only in IDLE.
- `abort` input 1: cancel the current transmission.
- `pattern` input PAT_W: bits to send; captured on accepted `start`.
- `len` input $clog2(PAT_W+1): number of bits to send, taken from `pattern[len-1:0]`.
- `reps` input REP_W: number of times to send the pattern; 0 is treated as 1.
- `out` output 1: serial bit (registered).
- `out_valid` output 1: high when `out` carries a pattern bit.
- `busy` output 1: high from the accepted `start` until `done`.
- `done` output 1: single-cycle completion pulse.

## Operation
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `done`=0. The FSM resets to IDLE and all counters to 0.
- FSM states:
  - IDLE: `start`=1 captures `pattern`, `len`, and `reps` → SHIFT. `len`=0 → FIN.
  - SHIFT: drive `pattern[bit_idx]`, starting with `bit_idx`=`len`-1 and decrementing. Last bit with reps remaining → GAP (feature on) or SHIFT with `bit_idx` reloaded (feature off). Last bit of the last rep → FIN.
  - GAP: `out`=0, `out_valid`=0 for GAP_CYC cycles → SHIFT.
  - FIN: `done`=1 for one cycle → IDLE.
- `len` > PAT_W saturates to PAT_W.
- `start` while `busy` is ignored. Captured inputs are frozen: changing `pattern` mid-transmission has no effect.
- `abort` wins over every other event. From any non-IDLE state it forces IDLE on the next edge with `out`=0, `out_valid`=0, `busy`=0, and no `done` pulse. `abort` in IDLE is a no-op. Simultaneous `start` and `abort` in IDLE: abort wins and `start` is dropped.
- `out`=0 whenever `out_valid`=0.
- Rep counter counts down from the effective reps value. Bit index wraps from 0 to `len`-1 at each rep boundary with no bubble when the gap feature is off.
- Reset asserted mid-operation: outputs return to reset values immediately, asynchronously.

## Timing
- `start` accepted at edge E0: first bit appears on `out` after E0, with `out_valid` and `busy` high.
- Bits occupy cycles E0..E0+len·reps−1 back-to-back, plus (reps−1)·GAP_CYC gap cycles if the feature is on.
- `done` is high in the cycle after the last valid bit. `busy` falls together with `done`. A new `start` is accepted in the `done` cycle's following IDLE, i.e. one cycle of idle between transmissions minimum.
- `len`=0: `busy` and `done` are both high for the single cycle after E0, and `out_valid` never rises.

## Configuration
- `SEQ_GEN_GAP_EN` defined: GAP state exists and GAP_CYC idle cycles are inserted between repetitions, never after the last rep.
- `SEQ_GEN_GAP_EN` undefined: GAP state and its counter are absent, repetitions are back-to-back, and GAP_CYC is ignored.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, GAP, FIN) with 2-bit encoding, shared with the detectors' state types;
  - default width constants for PAT_W and REP_W.
- One sub-module: `seq_gen_shreg`. It is the loadable pattern register and bit-index down-counter with wrap reload, and provides the current bit and a last-bit flag. The FSM and rep/gap counters stay in `seq_gen`.

## Test plan
- `pattern`=8'b0000_0111, `len`=3, `reps`=1 → `out`=1,1,1 on three cycles after E0 with `out_valid` high; `done` in the fourth cycle. A downstream three-ones detector sees its match.
- `pattern`=8'hA5, `len`=8, `reps`=2, feature off → `out`=10100101 10100101 contiguous (16 valid cycles), then a single `done`.
- Same stimulus with `SEQ_GEN_GAP_EN` and GAP_CYC=2 → 8 bits, 2 cycles with `out_valid`=0, 8 bits, then `done`. Total 18 cycles from E0 to last bit.
- `abort` on the 4th bit of an 8-bit pattern → next cycle `out`=0, `busy`=0, and `done` never pulses. A `start` two cycles later is accepted normally.
- `start` pulsed while `busy`, plus `len`=0 and `reps`=0 cases → the in-flight stream is unchanged. `len`=0 gives `done` one cycle after E0 with no valid bits. `reps`=0 sends the pattern exactly once.
- `rst` low mid-stream → all outputs 0 without waiting for a clock edge. After release, the block sits in IDLE and accepts `start`.
